ones_count_expander: RTL and testbench

- Inverse of the team's popcount block: accepts a ones-count and produces a DATA_WIDTH-bit unary (thermometer) frame containing exactly that many ones.
- Delivers the frame both as a registered parallel word and as a serial bitstream, LSB first, over a valid/ready handshake.
- Sits downstream of count producers and feeds bit-serial consumers or popcount checkers; a loopback through the popcount block must return the original count.

---
 rtl/ones_count_expander_if.sv | 24 ++
 rtl/ones_count_expander.sv | 57 +++++
 tb/tb_ones_count_expander.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ones_count_expander_if.sv
// ones_count_expander_if: count request and serial frame handshake bundle
interface ones_count_expander_if #(
  parameter int DATA_WIDTH = 16,
  localparam int CW = $clog2(DATA_WIDTH) + 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CW-1:0]         in_count;
  logic [DATA_WIDTH-1:0] therm;
  logic                  sat;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;
  logic                  out_first;
  logic                  out_last;
  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, therm, sat, out_valid, out_bit, out_first, out_last
  );
  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, therm, sat, out_valid, out_bit, out_first, out_last
  );
endinterface

// File: rtl/ones_count_expander.sv
// ones_count_expander: turns a ones-count into a thermometer word and an LSB-first serial frame
module ones_count_expander #(
  parameter int DATA_WIDTH = 16,
  localparam int CW = $clog2(DATA_WIDTH) + 1,
  localparam int IW = $clog2(DATA_WIDTH)
) (
  input logic clk,
  input logic rst_n,
  ones_count_expander_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_therm;
  logic                  r_sat;
  logic                  w_sat;
  logic [CW-1:0]         w_clamp;
  logic [DATA_WIDTH-1:0] w_therm;
  logic                  w_shift;
  assign w_sat   = bus.in_count > CW'(DATA_WIDTH);
  assign w_clamp = w_sat ? CW'(DATA_WIDTH) : bus.in_count;
  // thermometer of the clamped request: bit i set when i is below the count
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_therm[i] = CW'(i) < w_clamp;
  end
  // frame FSM: accept one count in IDLE, then walk idx across the frame on each accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_therm <= '0;
      r_sat   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.in_valid) begin
        r_cnt   <= w_clamp;
        r_sat   <= w_sat;
        r_therm <= w_therm;
        r_idx   <= '0;
        r_state <= SHIFT;
      end
    end else if (bus.out_ready) begin
      r_idx   <= (r_idx == IW'(DATA_WIDTH - 1)) ? '0 : r_idx + 1'b1;
      r_state <= (r_idx == IW'(DATA_WIDTH - 1)) ? IDLE : SHIFT;
    end
  end
  assign w_shift       = r_state == SHIFT;
  assign bus.in_ready  = !w_shift;
  assign bus.out_valid = w_shift;
  assign bus.out_bit   = w_shift && ({{(CW-IW){1'b0}}, r_idx} < r_cnt);
  assign bus.out_first = w_shift && (r_idx == '0);
  assign bus.out_last  = w_shift && (r_idx == IW'(DATA_WIDTH - 1));
  assign bus.therm     = r_therm;
  assign bus.sat       = r_sat;
endmodule

// File: tb/tb_ones_count_expander.sv
// tb_ones_count_expander: scoreboard bench for the count-to-thermometer expander
module tb_ones_count_expander;
  localparam int DW = 16;
  localparam int CW = $clog2(DW) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_last = 0;
  int beat = 0;
  int ones_ser = 0;
  int clamp = 0;
  bit stalled = 1'b0;
  logic [2:0] prev;
  logic [DW-1:0] exp_therm = '0;
  logic exp_sat = 1'b0;
  bit q[$];
  ones_count_expander_if #(.DATA_WIDTH(DW)) bus ();
  ones_count_expander #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // monitor: push expected frame on accept, pop and compare on every serial beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        logic [31:0] t;
        n_acc++;
        clamp = (int'(bus.in_count) > DW) ? DW : int'(bus.in_count);
        exp_sat = int'(bus.in_count) > DW;
        t = (32'd1 << clamp) - 32'd1;
        exp_therm = t[DW-1:0];
        for (int i = 0; i < DW; i++) q.push_back(i < clamp);
        beat = 0;
        ones_ser = 0;
        stalled = 1'b0;
      end
      if (bus.out_valid) begin
        if (stalled) chk("stall_hold", {bus.out_bit, bus.out_first, bus.out_last}, prev);
        if (bus.out_ready) begin
          if (q.size() == 0) chk("sb_empty", 1, 0);
          else chk("bit", bus.out_bit, q.pop_front());
          chk("first", bus.out_first, beat == 0);
          chk("last", bus.out_last, beat == DW - 1);
          if (bus.out_last) n_last++;
          ones_ser += int'(bus.out_bit);
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = {bus.out_bit, bus.out_first, bus.out_last};
        end
      end
    end
  end
  task automatic run_frame(input int c, input bit rnd, input bit hold);
    int acc0, cyc, t;
    acc0 = n_acc;
    bus.in_count = CW'(c);
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    bus.in_valid = hold;
    chk("rdy_fall", bus.in_ready, 0);
    cyc = 0;
    t = 0;
    while (!bus.in_ready && t < 400) begin
      cyc++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("timeout", t < 400, 1);
    if (!rnd) chk("frame_cycles", cyc, DW);
    chk("acc_once", n_acc - acc0, 1);
    chk("beats", beat, DW);
    chk("therm", bus.therm, exp_therm);
    chk("sat", bus.sat, exp_sat);
    chk("ser_pop", ones_ser, clamp);
    chk("therm_pop", $countones(bus.therm), clamp);
    chk("sb_drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    int t, lasts;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_therm", bus.therm, 0);
    chk("rst_outs", {bus.sat, bus.out_valid, bus.out_bit, bus.out_first, bus.out_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rdy", bus.in_ready, 1);
    run_frame(5, 0, 0);
    chk("t5_therm", bus.therm, 16'h001F);
    run_frame(0, 0, 0);
    run_frame(16, 0, 0);
    chk("t16_therm", bus.therm, 16'hFFFF);
    run_frame(20, 0, 0);
    chk("t20_sat", bus.sat, 1);
    run_frame(3, 0, 0);
    chk("t3_therm", bus.therm, 16'h0007);
    run_frame(9, 1, 1);
    run_frame(9, 1, 0);
    bus.in_count = CW'(12);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lasts = n_last;
    t = 0;
    while (beat < 7 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rst_wait", beat, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_therm", bus.therm, 0);
    chk("mid_rst_outs", {bus.sat, bus.out_valid, bus.out_bit, bus.out_first, bus.out_last}, 0);
    chk("no_last", n_last - lasts, 0);
    q.delete();
    stalled = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rel_rdy", bus.in_ready, 1);
    run_frame(2, 0, 0);
    for (int c = 0; c <= DW; c++) run_frame(c, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
